// File: rtl/fpnew_hub_result_arbiter_pkg.sv
// Constants and helpers for the HUB result arbiter and its output buffer.
package fpnew_hub_result_arbiter_pkg;

   localparam int unsigned BufDepth = 2;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fpnew_pkg.sv
// Shared FPnew definitions used by the HUB result path.
// Only the IEEE exception flag bundle is needed here.
package fpnew_pkg;

   typedef struct packed {
      logic NV;
      logic DZ;
      logic OF;
      logic UF;
      logic NX;
   } status_t;

endpackage

// File: rtl/fpnew_hub_out_buffer.sv
// Two-entry result FIFO; head visible the cycle after the first push, reads '0 when empty.
// Pushes while full and pops while empty are ignored; reset beats flush beats push/pop.
module fpnew_hub_out_buffer
   import fpnew_hub_result_arbiter_pkg::*;
#(
   parameter type entry_t = logic
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  entry_t     push_data,
   input  logic       pop,
   output entry_t     head,
   output logic [1:0] count
);

   entry_t mem [BufDepth];
   logic   rd_ptr;
   logic   wr_ptr;
   logic   wr_en;
   logic   rd_en;

   assign wr_en = push && (count != 2'(BufDepth));
   assign rd_en = pop && (count != 2'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (rd_en) rd_ptr <= ~rd_ptr;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Stale storage stays behind after a pop, so gate the head when empty.
   assign head = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fpnew_hub_result_arbiter.sv
// Round-robin merge of per-unit result handshakes into one buffered stream; latency 1 cycle.
// Inputs are granted only while the buffer has room, never combinationally from out_ready_i.
module fpnew_hub_result_arbiter
   import fpnew_hub_result_arbiter_pkg::*;
#(
   parameter int unsigned NumInputs = 2,
   parameter int unsigned Width     = 32,
   parameter type         TagType   = logic,
   localparam int unsigned SrcWidth = idx_width(NumInputs)
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NumInputs-1:0]                  in_valid_i,
   output logic [NumInputs-1:0]                  in_ready_o,
   input  logic [NumInputs-1:0][Width-1:0]       result_i,
   input  fpnew_pkg::status_t [NumInputs-1:0]    status_i,
   input  logic [NumInputs-1:0]                  ext_bit_i,
   input  TagType [NumInputs-1:0]                tag_i,
   input  logic                                  flush_i,
   output logic [Width-1:0]                      result_o,
   output fpnew_pkg::status_t                    status_o,
   output logic                                  extension_bit_o,
   output TagType                                tag_o,
   output logic [SrcWidth-1:0]                   src_o,
   output logic                                  out_valid_o,
   input  logic                                  out_ready_i,
   output logic                                  busy_o
);

   typedef struct packed {
      logic [Width-1:0]    result;
      fpnew_pkg::status_t  status;
      logic                ext_bit;
      TagType              tag;
      logic [SrcWidth-1:0] src;
   } entry_t;

   logic [SrcWidth-1:0]  rr_ptr;
   logic [SrcWidth-1:0]  sel;
   logic [SrcWidth-1:0]  cand;
   logic [NumInputs-1:0] grant;
   logic                 found;
   logic                 can_grant;
   logic                 push;
   logic                 pop;
   logic [1:0]           count;
   entry_t               push_data;
   entry_t               head;

   assign can_grant = (count < 2'(BufDepth)) && !flush_i;

   always_comb begin
      grant = '0;
      sel   = '0;
      cand  = '0;
      found = 1'b0;
      if (can_grant) begin
         for (int unsigned i = 0; i < NumInputs; i++) begin
            cand = SrcWidth'((32'(rr_ptr) + i) % NumInputs);
            if (!found && in_valid_i[cand]) begin
               found       = 1'b1;
               grant[cand] = 1'b1;
               sel         = cand;
            end
         end
      end
   end

   assign in_ready_o = grant & in_valid_i;
   assign push       = |in_ready_o;
   assign pop        = out_valid_o & out_ready_i;

   assign push_data.result  = result_i[sel];
   assign push_data.status  = status_i[sel];
   assign push_data.ext_bit = ext_bit_i[sel];
   assign push_data.tag     = tag_i[sel];
   assign push_data.src     = sel;

   // No push happens during a flush, so the pointer is naturally held then.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr <= '0;
      end else if (push) begin
         rr_ptr <= (32'(sel) == NumInputs - 1) ? '0 : sel + SrcWidth'(1);
      end
   end

   fpnew_hub_out_buffer #(
      .entry_t (entry_t)
   ) u_out_buffer (
      .clk       (clk_i),
      .rst       (rst_i),
      .flush     (flush_i),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   assign out_valid_o     = (count != 2'd0);
   assign busy_o          = (count != 2'd0);
   assign result_o        = head.result;
   assign status_o        = head.status;
   assign extension_bit_o = head.ext_bit;
   assign tag_o           = head.tag;
   assign src_o           = head.src;

endmodule

// File: tb/tb_fpnew_hub_result_arbiter.sv
// Scenario bench for the HUB result arbiter: expected entries are queued when offered and checked on emission.
module tb_fpnew_hub_result_arbiter;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  st;
      logic        ext;
      logic [3:0]  tag;
      logic        src;
   } exp_t;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     flush = 1'b0;
   logic                     out_ready = 1'b0;
   logic [1:0]               in_valid = '0;
   logic [1:0][31:0]         result = '0;
   fpnew_pkg::status_t [1:0] status = '0;
   logic [1:0]               ext = '0;
   logic [1:0][3:0]          tag = '0;

   logic [1:0]               in_ready;
   logic [31:0]              result_out;
   fpnew_pkg::status_t       status_out;
   logic                     ext_out;
   logic [3:0]               tag_out;
   logic                     src_out;
   logic                     out_valid;
   logic                     busy;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   fpnew_hub_result_arbiter #(
      .NumInputs (2),
      .Width     (32),
      .TagType   (logic [3:0])
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .in_valid_i      (in_valid),
      .in_ready_o      (in_ready),
      .result_i        (result),
      .status_i        (status),
      .ext_bit_i       (ext),
      .tag_i           (tag),
      .flush_i         (flush),
      .result_o        (result_out),
      .status_o        (status_out),
      .extension_bit_o (ext_out),
      .tag_o           (tag_out),
      .src_o           (src_out),
      .out_valid_o     (out_valid),
      .out_ready_i     (out_ready),
      .busy_o          (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "timeout");
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = '0; flush = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      sb_q.delete();
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = '0; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (in_ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", in_ready); end
      tests++;
      if ({result_out, status_out, ext_out, tag_out, src_out} !== 43'd0) begin
         fails++; $display("FAIL reset_fields: got res=%h st=%b ext=%b tag=%h src=%0d want all zero",
                           result_out, status_out, ext_out, tag_out, src_out);
      end
   endtask

   task automatic test_single();
      exp_t e;
      apply_reset();
      @(negedge clk);
      in_valid = 2'b01; result[0] = 32'h3F80_0000; status[0] = '0; ext[0] = 1'b1; tag[0] = 4'h3; out_ready = 1'b1;
      #1;
      tests++; if (in_ready !== 2'b01) begin fails++; $display("FAIL single_grant: got %b want 01", in_ready); end
      sb_q.push_back({32'h3F80_0000, 5'b00000, 1'b1, 4'h3, 1'b0});
      @(negedge clk);
      in_valid = 2'b00;
      #1;
      tests++;
      if (sb_q.size() == 0) begin fails++; $display("FAIL single_out: scoreboard empty"); end
      else begin
         e = sb_q.pop_front();
         if (out_valid !== 1'b1 || result_out !== e.res || status_out !== e.st || ext_out !== e.ext || tag_out !== e.tag || src_out !== e.src) begin
            fails++; $display("FAIL single_out: got v=%b res=%h st=%b ext=%b tag=%h src=%0d want v=1 res=%h st=%b ext=%b tag=%h src=%0d",
                              out_valid, result_out, status_out, ext_out, tag_out, src_out, e.res, e.st, e.ext, e.tag, e.src);
         end
      end
      @(negedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b0 || result_out !== 32'd0 || src_out !== 1'b0) begin
         fails++; $display("FAIL single_drain: got v=%b res=%h src=%0d want v=0 res=0 src=0", out_valid, result_out, src_out);
      end
   endtask

   task automatic test_round_robin();
      exp_t e;
      int   k_exp;
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = 2'b11;
         for (int k = 0; k < 2; k++) begin
            result[k] = 32'h1000_0000 + 32'(i * 16 + k);
            status[k] = fpnew_pkg::status_t'(5'(i + k));
            ext[k]    = k[0];
            tag[k]    = 4'(i + 8 * k);
         end
         #1;
         k_exp = i % 2;
         tests++; if (in_ready !== 2'(1 << k_exp)) begin fails++; $display("FAIL rr_grant[%0d]: got %b want %b", i, in_ready, 2'(1 << k_exp)); end
         if (i > 0) begin
            tests++;
            if (sb_q.size() == 0) begin fails++; $display("FAIL rr_out[%0d]: scoreboard empty", i); end
            else begin
               e = sb_q.pop_front();
               if (out_valid !== 1'b1 || result_out !== e.res || status_out !== e.st || ext_out !== e.ext || tag_out !== e.tag || src_out !== e.src) begin
                  fails++; $display("FAIL rr_out[%0d]: got v=%b res=%h src=%0d tag=%h want v=1 res=%h src=%0d tag=%h",
                                    i, out_valid, result_out, src_out, tag_out, e.res, e.src, e.tag);
               end
            end
         end
         sb_q.push_back({result[k_exp], 5'(status[k_exp]), ext[k_exp], tag[k_exp], 1'(k_exp)});
      end
      @(negedge clk);
      in_valid = 2'b00;
      #1;
      tests++;
      if (sb_q.size() == 0) begin fails++; $display("FAIL rr_last: scoreboard empty"); end
      else begin
         e = sb_q.pop_front();
         if (out_valid !== 1'b1 || result_out !== e.res || src_out !== e.src) begin
            fails++; $display("FAIL rr_last: got v=%b res=%h src=%0d want v=1 res=%h src=%0d", out_valid, result_out, src_out, e.res, e.src);
         end
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      apply_reset();
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 2'b10; result[1] = 32'hA0A0_0001; status[1] = 5'b00001; ext[1] = 1'b1; tag[1] = 4'h5;
      #1;
      tests++; if (in_ready !== 2'b10) begin fails++; $display("FAIL bp_acc0: got %b want 10", in_ready); end
      sb_q.push_back({32'hA0A0_0001, 5'b00001, 1'b1, 4'h5, 1'b1});
      @(negedge clk);
      result[1] = 32'hB0B0_0002; status[1] = 5'b00100; ext[1] = 1'b0; tag[1] = 4'h6;
      #1;
      tests++; if (in_ready !== 2'b10) begin fails++; $display("FAIL bp_acc1: got %b want 10", in_ready); end
      sb_q.push_back({32'hB0B0_0002, 5'b00100, 1'b0, 4'h6, 1'b1});
      @(negedge clk);
      result[1] = 32'hC0C0_0003; status[1] = 5'b01000; ext[1] = 1'b1; tag[1] = 4'h7;
      #1;
      tests++; if (in_ready !== 2'b00) begin fails++; $display("FAIL bp_full: got %b want 00", in_ready); end
      tests++;
      if (out_valid !== 1'b1 || result_out !== sb_q[0].res || status_out !== 5'b00001 || tag_out !== 4'h5) begin
         fails++; $display("FAIL bp_head: got v=%b res=%h st=%b tag=%h want v=1 res=%h st=00001 tag=5", out_valid, result_out, status_out, tag_out, sb_q[0].res);
      end
      @(negedge clk);
      #1;
      tests++;
      if (status_out !== 5'b00001 || tag_out !== 4'h5 || ext_out !== 1'b1 || result_out !== 32'hA0A0_0001) begin
         fails++; $display("FAIL bp_stable: got res=%h st=%b ext=%b tag=%h want res=a0a00001 st=00001 ext=1 tag=5", result_out, status_out, ext_out, tag_out);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      tests++; if (in_ready !== 2'b00) begin fails++; $display("FAIL bp_full_ready: got %b want 00", in_ready); end
      for (int n = 0; n < 3; n++) begin
         if (n > 0) begin
            @(negedge clk);
            if (n == 1) in_valid = 2'b10;
            else in_valid = 2'b00;
            #1;
         end
         if (n == 1) begin
            tests++; if (in_ready !== 2'b10) begin fails++; $display("FAIL bp_refill: got %b want 10", in_ready); end
         end
         tests++;
         if (sb_q.size() == 0) begin fails++; $display("FAIL bp_out[%0d]: scoreboard empty", n); end
         else begin
            e = sb_q.pop_front();
            if (out_valid !== 1'b1 || result_out !== e.res || status_out !== e.st || ext_out !== e.ext || tag_out !== e.tag || src_out !== e.src) begin
               fails++; $display("FAIL bp_out[%0d]: got v=%b res=%h st=%b ext=%b tag=%h src=%0d want v=1 res=%h st=%b ext=%b tag=%h src=%0d",
                                 n, out_valid, result_out, status_out, ext_out, tag_out, src_out, e.res, e.st, e.ext, e.tag, e.src);
            end
         end
         if (n == 1) sb_q.push_back({32'hC0C0_0003, 5'b01000, 1'b1, 4'h7, 1'b1});
      end
      @(negedge clk);
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_flush();
      exp_t e;
      apply_reset();
      out_ready = 1'b0;
      for (int n = 0; n < 2; n++) begin
         @(negedge clk);
         in_valid = 2'b01; result[0] = 32'hF000_0000 + 32'(n);
         #1;
         tests++; if (in_ready !== 2'b01) begin fails++; $display("FAIL flush_fill[%0d]: got %b want 01", n, in_ready); end
      end
      @(negedge clk);
      in_valid = 2'b11; flush = 1'b1;
      #1;
      tests++; if (in_ready !== 2'b00) begin fails++; $display("FAIL flush_noacc: got %b want 00", in_ready); end
      @(negedge clk);
      flush = 1'b0; in_valid = 2'b00;
      #1;
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL flush_empty: got v=%b busy=%b want 0 0", out_valid, busy); end
      @(negedge clk);
      in_valid = 2'b11; result[0] = 32'hF000_0010; result[1] = 32'hF000_0011; status[1] = 5'b10000; ext[1] = 1'b0; tag[1] = 4'h9;
      out_ready = 1'b1;
      #1;
      tests++; if (in_ready !== 2'b10) begin fails++; $display("FAIL flush_rr_held: got %b want 10", in_ready); end
      sb_q.push_back({32'hF000_0011, 5'b10000, 1'b0, 4'h9, 1'b1});
      @(negedge clk);
      in_valid = 2'b00;
      #1;
      tests++;
      if (sb_q.size() == 0) begin fails++; $display("FAIL flush_out: scoreboard empty"); end
      else begin
         e = sb_q.pop_front();
         if (out_valid !== 1'b1 || result_out !== e.res || src_out !== e.src || status_out !== e.st) begin
            fails++; $display("FAIL flush_out: got v=%b res=%h src=%0d st=%b want v=1 res=%h src=%0d st=%b",
                              out_valid, result_out, src_out, status_out, e.res, e.src, e.st);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      apply_reset();
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 2'b01; result[0] = 32'hDEAD_0001;
      #1;
      tests++; if (in_ready !== 2'b01) begin fails++; $display("FAIL rstmid_acc: got %b want 01", in_ready); end
      @(negedge clk);
      in_valid = 2'b00; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_drop: got v=%b busy=%b want 0 0", out_valid, busy); end
      @(negedge clk);
      in_valid = 2'b11; result[0] = 32'h0BAD_0002; result[1] = 32'h0BAD_0003; status[0] = '0; ext[0] = 1'b0; tag[0] = 4'h1;
      out_ready = 1'b1;
      #1;
      tests++; if (in_ready !== 2'b01) begin fails++; $display("FAIL rstmid_rr: got %b want 01", in_ready); end
      sb_q.push_back({32'h0BAD_0002, 5'b00000, 1'b0, 4'h1, 1'b0});
      @(negedge clk);
      in_valid = 2'b00;
      #1;
      tests++;
      if (sb_q.size() == 0) begin fails++; $display("FAIL rstmid_out: scoreboard empty"); end
      else begin
         e = sb_q.pop_front();
         if (out_valid !== 1'b1 || result_out !== e.res || src_out !== e.src || tag_out !== e.tag) begin
            fails++; $display("FAIL rstmid_out: got v=%b res=%h src=%0d tag=%h want v=1 res=%h src=%0d tag=%h",
                              out_valid, result_out, src_out, tag_out, e.res, e.src, e.tag);
         end
      end
      @(negedge clk);
      #1;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_empty: got %b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
